// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the multicycle multiplier issue/retire controller.
// Holds the FSM state encoding, the default datapath width and the counter sizing.
package mul_issue_ctrl_pkg;

    localparam int MUL_WIDTH   = 64;
    localparam int MUL_CNT_W   = 4;
    localparam int MUL_LAT_MAX = (1 << MUL_CNT_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    function automatic logic mul_lat_legal(input int lat);
        return (lat >= 1) && (lat <= MUL_LAT_MAX);
    endfunction

endpackage

// File: rtl/mul_bypass_detect.sv
// Zero/one operand detector for the multiply short-cut; exists only with MUL_BYPASS_EN.
// Purely combinational; the controller decides when the hit is acted on.
`ifdef MUL_BYPASS_EN
module mul_bypass_detect
    import mul_issue_ctrl_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_hit,
    output logic [WIDTH-1:0] o_val
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic w_a_zero;
    logic w_b_zero;
    logic w_a_one;
    logic w_b_one;

    assign w_a_zero = (i_op_a == '0);
    assign w_b_zero = (i_op_b == '0);
    assign w_a_one  = (i_op_a == ONE);
    assign w_b_one  = (i_op_b == ONE);

    // Zero wins over one so 0*1 and 1*0 both produce zero.
    always_comb begin
        o_hit = 1'b0;
        o_val = '0;
        if (w_a_zero || w_b_zero) begin
            o_hit = 1'b1;
            o_val = '0;
        end else if (w_a_one) begin
            o_hit = 1'b1;
            o_val = i_op_b;
        end else if (w_b_one) begin
            o_hit = 1'b1;
            o_val = i_op_a;
        end
    end

endmodule
`endif

// File: rtl/mul_issue_ctrl.sv
// Multicycle multiplier issue/retire control: result valid LAT edges after accept (same edge with MUL_BYPASS_EN
// on 0/1 operands); one operation in flight, DONE holds result indefinitely while out_ready is low.
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    // LAT must stay within 1..MUL_LAT_MAX so LAT-1 fits the counter.
    localparam logic [MUL_CNT_W-1:0] CNT_INIT = MUL_CNT_W'(LAT - 1);

    mul_state_e             r_state;
    mul_state_e             w_state_nxt;
    logic [MUL_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]       r_mul_a;
    logic [WIDTH-1:0]       r_mul_b;
    logic [WIDTH-1:0]       r_result;
    logic                   w_accept;
    logic                   w_calc_done;

`ifdef MUL_BYPASS_EN
    logic                   w_byp_hit;
    logic [WIDTH-1:0]       w_byp_val;

    mul_bypass_detect #(
        .WIDTH (WIDTH)
    ) u_bypass (
        .i_op_a (op_a),
        .i_op_b (op_b),
        .o_hit  (w_byp_hit),
        .o_val  (w_byp_val)
    );
`endif

    assign w_accept    = !flush && (r_state == ST_IDLE) && in_valid;
    assign w_calc_done = !flush && (r_state == ST_CALC) && (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
`ifdef MUL_BYPASS_EN
                        w_state_nxt = w_byp_hit ? ST_DONE : ST_CALC;
`else
                        w_state_nxt = ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        busy      = (r_state == ST_CALC) || (r_state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_INIT;
        end else if ((r_state == ST_CALC) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Operands stay frozen from accept to the next accept: the multicycle path relies on it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else if (w_accept) begin
            r_mul_a <= op_a;
            r_mul_b <= op_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
        end else if (w_calc_done) begin
            r_result <= mul_y;
`ifdef MUL_BYPASS_EN
        end else if (w_accept && w_byp_hit) begin
            r_result <= w_byp_val;
`endif
        end
    end

    assign mul_a  = r_mul_a;
    assign mul_b  = r_mul_b;
    assign result = r_result;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: directed timing/flush/reset cases, then random traffic
// checked by a queue scoreboard against plain modular multiplication.
module tb_mul_issue_ctrl;

    localparam int W   = 64;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic [W-1:0] mul_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    typedef struct {
        logic [W-1:0] y;
        int           acc;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;
    bit   prev_ov = 1'b0;

    mul_issue_ctrl #(.WIDTH(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_y     (mul_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    // Stand-in for the external combinational multiplier core.
    assign mul_y = mul_a * mul_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_BYPASS_EN
        if (a == 0 || b == 0 || a == 1 || b == 1) return 0;
`endif
        return LAT;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = 64'd1;
            2: v = '1;
            3: v = 64'h8000_0000_0000_0000;
            4: v = 64'($urandom_range(0, 255));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Offers one operation, measures edges until out_valid, checks result, then retires it.
    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] expv);
        int n;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op_a      = a;
        op_b      = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(exp_lat(a, b)));
        chk({nm, "_result"}, result, expv);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_retired"}, {63'd0, in_ready}, 64'd1);
        out_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (out_valid) begin
                chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    chk("sb_result", result, exp_q[0].y);
                    if (!prev_ov)
                        chk("sb_latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        bit flush_prev;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mul_a", mul_a, 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b0;

        // 7*6 with consumer stalled, then ten cycles of backpressure
        in_valid = 1'b1; op_a = 64'd7; op_b = 64'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("basic_in_ready_e0", {63'd0, in_ready}, 64'd0);
        chk("basic_busy_e0", {63'd0, busy}, 64'd1);
        chk("basic_mul_a", mul_a, 64'd7);
        chk("basic_mul_b", mul_b, 64'd6);
        @(posedge clk); #1;
        chk("basic_out_valid_e1", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        chk("basic_out_valid_e2", {63'd0, out_valid}, 64'd1);
        chk("basic_result", result, 64'd42);
        in_valid = 1'b1; op_a = 64'd99; op_b = 64'd98;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_result", result, 64'd42);
            chk("bp_mul_a", mul_a, 64'd7);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b0;

        do_op("wrap_pow2", 64'h8000_0000_0000_0000, 64'd2, 64'd0);
        do_op("wrap_ones", '1, '1, 64'd1);

        // flush in CALC
        in_valid = 1'b1; op_a = 64'd9; op_b = 64'd9;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flc_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flc_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flc_busy", {63'd0, busy}, 64'd0);
        repeat (4) begin @(posedge clk); #1; end
        chk("flc_no_result", {63'd0, out_valid}, 64'd0);
        chk("flc_mul_a_kept", mul_a, 64'd9);

        // flush in DONE
        in_valid = 1'b1; op_a = 64'd4; op_b = 64'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (LAT) begin @(posedge clk); #1; end
        chk("fld_done", {63'd0, out_valid}, 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fld_out_valid", {63'd0, out_valid}, 64'd0);
        chk("fld_result_kept", result, 64'd16);
        do_op("after_flush", 64'd3, 64'd5, 64'd15);

        // asynchronous reset in the middle of CALC
        in_valid = 1'b1; op_a = 64'd11; op_b = 64'd13;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_mul_a", mul_a, 64'd0);
        chk("arst_mul_b", mul_b, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("post_rst", 64'd6, 64'd7, 64'd42);

        do_op("zero_a", 64'd0, 64'd123, 64'd0);
        do_op("one_a", 64'd1, 64'hDEAD, 64'hDEAD);
        do_op("one_b", 64'h1234_5678_9ABC_DEF0, 64'd1, 64'h1234_5678_9ABC_DEF0);

        // random traffic against the scoreboard
        prev_ov = 1'b0;
        mon_en = 1'b1;
        flush_prev = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic fl;
            if (flush_prev) exp_q.delete();
            fl        = ($urandom_range(0, 39) == 0);
            out_ready = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1) != 0;
            op_a      = pick();
            op_b      = pick();
            flush     = fl;
            if (!fl && in_valid && in_ready)
                exp_q.push_back('{y: op_a * op_b, acc: cyc + 1, lat: exp_lat(op_a, op_b)});
            flush_prev = fl;
            @(posedge clk); #1;
        end
        if (flush_prev) exp_q.delete();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (LAT + 4) begin @(posedge clk); #1; end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
